dct8x8_row_unpack: RTL and testbench

Read-side companion to the 8x8 DCT transpose buffer controller. It consumes the buffer's 2-row output beats (4 beats per 8x8 block, rows 0/1, 2/3, 4/5, 6/7) over a valid/ready handshake and re-emits them as single 8-sample rows, one per cycle, with row index and end-of-block marker. It sits between the buffer datapath and the row-wise 1-D DCT/quantiser stage. A 2-slot pair store lets a new beat land while the previous one drains, giving sustained 1 row/cycle.

---
 rtl/dct8x8_pkg.sv | 31 +++
 rtl/dct8x8_row_unpack_if.sv | 50 +++++
 rtl/dct8x8_pair_slots.sv | 52 +++++
 rtl/dct8x8_row_unpack.sv | 131 +++++++++++++
 tb/tb_dct8x8_row_unpack.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/dct8x8_pkg.sv
// ---------------------------------------------------------------------------
// dct8x8_pkg
// Constants and types shared by the 8x8 DCT transpose buffer controller and
// its read-side row unpacker.
//   DCT_N          : samples per row and rows per block
//   ROWS_PER_BEAT  : rows carried by one buffer output beat
//   BEATS_PER_BLK  : beats that make up one 8x8 block
//   ROW_IDX_W      : width of a row index within a block
//   occ_state_e    : occupancy of the two-slot pair store
// ---------------------------------------------------------------------------
package dct8x8_pkg;

  localparam int DCT_N         = 8;
  localparam int ROWS_PER_BEAT = 2;
  localparam int BEATS_PER_BLK = 4;
  localparam int ROW_IDX_W     = $clog2(BEATS_PER_BLK * ROWS_PER_BEAT);

  // Number of filled pair slots; EMPTY must stay the all-zero encoding so the
  // reset value reads naturally in waveforms.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_e;

  // True when the given index is the final row of a block.
  function automatic logic is_last_row(input logic [ROW_IDX_W-1:0] idx);
    return idx == ROW_IDX_W'(DCT_N - 1);
  endfunction

endpackage

// File: rtl/dct8x8_row_unpack_if.sv
// ---------------------------------------------------------------------------
// dct8x8_row_unpack_if
// Bundles the beat-side and row-side handshakes of the row unpacker.
//   pair_vld_i / pair_rdy_i / pair_data_i : 2-row beats from the buffer
//   row_vld_o / row_rdy_o / row_data_o    : single rows to the 1-D DCT stage
//   row_idx_o / row_last_o                : position of the row in its block
//   busy_o                                : unpacker holds or owes data
// The slave modport is the unpacker's view, master is the environment's view.
// ---------------------------------------------------------------------------
interface dct8x8_row_unpack_if
  import dct8x8_pkg::*;
#(
  parameter int DW = 16
);

  logic                                   pair_vld_i;
  logic                                   pair_rdy_i;
  logic [DCT_N*ROWS_PER_BEAT*DW-1:0]      pair_data_i;
  logic                                   row_vld_o;
  logic                                   row_rdy_o;
  logic [DCT_N*DW-1:0]                    row_data_o;
  logic [ROW_IDX_W-1:0]                   row_idx_o;
  logic                                   row_last_o;
  logic                                   busy_o;

  modport slave (
    input  pair_vld_i,
    input  pair_data_i,
    input  row_rdy_o,
    output pair_rdy_i,
    output row_vld_o,
    output row_data_o,
    output row_idx_o,
    output row_last_o,
    output busy_o
  );

  modport master (
    output pair_vld_i,
    output pair_data_i,
    output row_rdy_o,
    input  pair_rdy_i,
    input  row_vld_o,
    input  row_data_o,
    input  row_idx_o,
    input  row_last_o,
    input  busy_o
  );

endinterface

// File: rtl/dct8x8_pair_slots.sv
// ---------------------------------------------------------------------------
// dct8x8_pair_slots
// Two-entry register file holding 2-row beats. One synchronous write port
// and one combinational read port that returns either half of a slot.
//   clk, rst_n  : clock, asynchronous active-low reset (slots clear to 0)
//   wr_en_i     : write strobe
//   wr_sel_i    : slot to write
//   wr_data_i   : beat to store (even row in low half, odd row in high half)
//   rd_sel_i    : slot to read
//   rd_half_i   : 0 = even row, 1 = odd row
//   rd_data_o   : selected row
// ---------------------------------------------------------------------------
module dct8x8_pair_slots
  import dct8x8_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en_i,
  input  logic                              wr_sel_i,
  input  logic [DCT_N*ROWS_PER_BEAT*DW-1:0] wr_data_i,
  input  logic                              rd_sel_i,
  input  logic                              rd_half_i,
  output logic [DCT_N*DW-1:0]               rd_data_o
);

  localparam int RW = DCT_N * DW;
  localparam int PW = ROWS_PER_BEAT * RW;

  logic [PW-1:0] slot_q [2];

  // Slot storage. Clearing on reset keeps the row output at zero until the
  // first beat arrives, so the downstream stage never sees stale X data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
    end else if (wr_en_i) begin
      slot_q[wr_sel_i] <= wr_data_i;
    end
  end

  // Read port: pick the slot, then the row half within it.
  always_comb begin
    rd_data_o = slot_q[rd_sel_i][RW-1:0];
    if (rd_half_i) begin
      rd_data_o = slot_q[rd_sel_i][PW-1:RW];
    end
  end

endmodule

// File: rtl/dct8x8_row_unpack.sv
// ---------------------------------------------------------------------------
// dct8x8_row_unpack
// Takes 2-row beats from the transpose buffer and re-emits them one 8-sample
// row per cycle, tagged with the row index inside the block and an
// end-of-block flag. A two-slot store lets the next beat land while the odd
// row of the current beat is still waiting, which sustains 1 row/cycle.
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus.pair_vld_i/rdy  : beat handshake (rdy depends on occupancy only)
//   bus.pair_data_i     : beat, even row in low half
//   bus.row_vld_o/rdy   : row handshake
//   bus.row_data_o      : current row, sample 0 in LSBs
//   bus.row_idx_o       : row index 0..7 in block
//   bus.row_last_o      : high with row 7
//   bus.busy_o          : store non-empty or block partially emitted
// ---------------------------------------------------------------------------
module dct8x8_row_unpack
  import dct8x8_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dct8x8_row_unpack_if.slave   bus
);

  localparam int RW = DCT_N * DW;

  occ_state_e            state_q, state_d;
  logic                  wsel_q, wsel_d;
  logic                  rsel_q, rsel_d;
  logic [ROW_IDX_W-1:0]  ridx_q, ridx_d;

  logic                  pair_rdy;
  logic                  row_vld;
  logic                  accept;
  logic                  emit;
  logic                  rel;
  logic [RW-1:0]         row_data;

  // Handshake qualifiers. The beat-side ready looks only at occupancy so
  // there is no combinational path from the downstream ready back upstream.
  // The odd half of a slot is always ridx[0], so emitting with ridx[0] set
  // means the slot has been fully drained.
  assign pair_rdy = (state_q != FULL);
  assign row_vld  = (state_q != EMPTY);
  assign accept   = bus.pair_vld_i && pair_rdy;
  assign emit     = row_vld && bus.row_rdy_o;
  assign rel      = emit && ridx_q[0];

  // State register: occupancy, slot pointers and row counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      wsel_q  <= 1'b0;
      rsel_q  <= 1'b0;
      ridx_q  <= '0;
    end else begin
      state_q <= state_d;
      wsel_q  <= wsel_d;
      rsel_q  <= rsel_d;
      ridx_q  <= ridx_d;
    end
  end

  // Next-state logic. In ONE an accept and a release in the same cycle
  // cancel out; the new beat goes to the free slot because wsel and rsel
  // differ whenever exactly one slot is occupied. FULL blocks accepts via
  // pair_rdy, so no write can land on an occupied slot.
  always_comb begin
    state_d = state_q;
    wsel_d  = wsel_q;
    rsel_d  = rsel_q;
    ridx_d  = ridx_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && !rel) begin
          state_d = FULL;
        end else if (!accept && rel) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (rel) begin
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    if (accept) begin
      wsel_d = ~wsel_q;
    end
    if (emit) begin
      ridx_d = ridx_q + 1'b1;
    end
    if (rel) begin
      rsel_d = ~rsel_q;
    end
  end

  dct8x8_pair_slots #(
    .DW        (DW)
  ) u_slots (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (accept),
    .wr_sel_i  (wsel_q),
    .wr_data_i (bus.pair_data_i),
    .rd_sel_i  (rsel_q),
    .rd_half_i (ridx_q[0]),
    .rd_data_o (row_data)
  );

  // Outputs. Everything comes from registered state, so the row fields stay
  // stable for as long as the downstream stage stalls.
  assign bus.pair_rdy_i = pair_rdy;
  assign bus.row_vld_o  = row_vld;
  assign bus.row_data_o = row_data;
  assign bus.row_idx_o  = ridx_q;
  assign bus.row_last_o = row_vld && is_last_row(ridx_q);
  assign bus.busy_o     = row_vld || (ridx_q != '0);

endmodule

// File: tb/tb_dct8x8_row_unpack.sv
// ---------------------------------------------------------------------------
// tb_dct8x8_row_unpack
// Self-checking bench for the row unpacker. The reference model is a plain
// queue of expected rows plus a count of beats held, advanced from the
// handshakes the model itself predicts.
// ---------------------------------------------------------------------------
module tb_dct8x8_row_unpack;
  import dct8x8_pkg::*;

  localparam int DW = 16;
  localparam int RW = DCT_N * DW;
  localparam int PW = ROWS_PER_BEAT * RW;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  dct8x8_row_unpack_if #(.DW(DW)) bus ();

  dct8x8_row_unpack #(.DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Reference model state.
  logic [RW-1:0] expQ[$];
  int occ        = 0;
  int emitCount  = 0;
  int beatsAcc   = 0;
  int cycleNo    = 0;

  // Observed DUT row handshakes, sampled at check time.
  int dutEmits   = 0;
  int dutFirst   = -1;
  int dutLast    = -1;

  int nChecks    = 0;
  int nErrors    = 0;

  // Single comparison point.
  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] comparison %s", tag);
    end
  endtask

  // Beat with sample value blk*256 + row*8 + col.
  function automatic logic [PW-1:0] mkBeat(input int blk, input int k);
    logic [PW-1:0] b;
    b = '0;
    for (int r = 0; r < ROWS_PER_BEAT; r++) begin
      for (int c = 0; c < DCT_N; c++) begin
        b[(r*DCT_N + c)*DW +: DW] = DW'(blk*256 + (2*k + r)*DCT_N + c);
      end
    end
    return b;
  endfunction

  function automatic logic [PW-1:0] rndBeat();
    logic [PW-1:0] b;
    for (int i = 0; i < PW/32; i++) begin
      b[i*32 +: 32] = $urandom;
    end
    return b;
  endfunction

  // Compare all outputs against the model for the current cycle.
  task automatic checkOutput();
    int idx;
    logic expVld;
    idx    = emitCount % DCT_N;
    expVld = (occ > 0);
    check("pair_rdy", RW'(bus.pair_rdy_i), RW'(occ < 2));
    check("row_vld",  RW'(bus.row_vld_o),  RW'(expVld));
    check("row_last", RW'(bus.row_last_o), RW'(expVld && idx == DCT_N-1));
    check("busy",     RW'(bus.busy_o),     RW'(expVld || idx != 0));
    if (expVld) begin
      check("row_data", bus.row_data_o, expQ[0]);
      check("row_idx",  RW'(bus.row_idx_o), RW'(idx));
    end
    if (bus.row_vld_o === 1'b1 && bus.row_rdy_o === 1'b1) begin
      dutEmits++;
      if (dutFirst < 0) dutFirst = cycleNo;
      dutLast = cycleNo;
    end
  endtask

  // One clock: drive at negedge, check, then advance the model at posedge.
  task automatic applyStimulus(input logic v, input logic [PW-1:0] d, input logic r);
    bit acc;
    bit em;
    @(negedge clk);
    bus.pair_vld_i  = v;
    bus.pair_data_i = d;
    bus.row_rdy_o   = r;
    #1;
    checkOutput();
    @(posedge clk);
    acc = v && (occ < 2);
    em  = (occ > 0) && r;
    if (em) begin
      void'(expQ.pop_front());
      if (emitCount % 2 == 1) occ--;
      emitCount++;
    end
    if (acc) begin
      expQ.push_back(d[RW-1:0]);
      expQ.push_back(d[PW-1:RW]);
      occ++;
      beatsAcc++;
    end
    cycleNo++;
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_pair_rdy"}, RW'(bus.pair_rdy_i), RW'(1));
    check({tag, "_row_vld"},  RW'(bus.row_vld_o),  RW'(0));
    check({tag, "_row_data"}, bus.row_data_o,      RW'(0));
    check({tag, "_row_idx"},  RW'(bus.row_idx_o),  RW'(0));
    check({tag, "_row_last"}, RW'(bus.row_last_o), RW'(0));
    check({tag, "_busy"},     RW'(bus.busy_o),     RW'(0));
  endtask

  // Asynchronous reset a few ns after an edge; outputs must react at once.
  task automatic doReset();
    #2;
    bus.pair_vld_i = 1'b0;
    rst_n = 1'b0;
    #1;
    checkReset("async_rst");
    expQ.delete();
    occ = 0;
    emitCount = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offer nBeats beats with the given vld/rdy probabilities; row_rdy_o is
  // forced low for the first 'stall' cycles. Bounded by maxCyc.
  task automatic streamBeats(input int nBeats, input int blk0, input bit rndData,
                             input int vldPct, input int rdyPct, input int stall,
                             input int maxCyc, input string tag);
    int sent;
    int cyc;
    int prevAcc;
    logic [PW-1:0] beat;
    logic v;
    logic r;
    sent = 0;
    cyc  = 0;
    beat = rndData ? rndBeat() : mkBeat(blk0, 0);
    while ((sent < nBeats || occ > 0) && cyc < maxCyc) begin
      v = (sent < nBeats) && ($urandom_range(99) < vldPct);
      r = (cyc >= stall) && ($urandom_range(99) < rdyPct);
      prevAcc = beatsAcc;
      applyStimulus(v, beat, r);
      if (beatsAcc != prevAcc) begin
        sent++;
        beat = rndData ? rndBeat() : mkBeat(blk0 + sent/4, sent%4);
      end
      cyc++;
    end
    check({tag, "_done"}, RW'(sent == nBeats && occ == 0), RW'(1));
  endtask

  initial begin
    int startEmits;

    rst_n           = 1'b0;
    bus.pair_vld_i  = 1'b0;
    bus.pair_data_i = '0;
    bus.row_rdy_o   = 1'b0;
    #1;
    $display("[TB] reset values");
    checkReset("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single block");
    streamBeats(4, 0, 1'b0, 100, 100, 0, 50, "single");
    applyStimulus(1'b0, '0, 1'b1);

    $display("[TB] back-to-back blocks");
    startEmits = dutEmits;
    dutFirst   = -1;
    streamBeats(12, 1, 1'b0, 100, 100, 0, 200, "b2b");
    check("b2b_rows", RW'(dutEmits - startEmits), RW'(24));
    check("b2b_span", RW'(dutLast - dutFirst + 1), RW'(24));

    $display("[TB] downstream stall");
    streamBeats(4, 4, 1'b0, 100, 100, 11, 100, "stall");

    $display("[TB] accept and release together");
    applyStimulus(1'b1, mkBeat(5, 0), 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, mkBeat(5, 1), 1'b1);
    streamBeats(2, 5, 1'b0, 100, 100, 0, 50, "simul");

    $display("[TB] reset mid-block");
    applyStimulus(1'b1, mkBeat(6, 0), 1'b1);
    applyStimulus(1'b1, mkBeat(6, 1), 1'b1);
    for (int i = 0; i < 10 && emitCount < 4; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
    end
    doReset();
    streamBeats(4, 7, 1'b0, 100, 100, 0, 50, "after_rst");

    $display("[TB] randomised traffic");
    streamBeats(800, 0, 1'b1, 70, 60, 0, 20000, "random");

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
